// File: rtl/mccoy_pkg.sv
// Shared definitions for the McCoy host: interface widths, FSM states and
// the layout of one trace word.
package mccoy_pkg;

    localparam int INSTR_W    = 6;
    localparam int PC_W       = 6;
    localparam int X8_W       = 6;
    localparam int TRACE_W    = PC_W + X8_W;
    localparam int PROG_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CRST = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    // Trace word: PC in the upper half, x8 in the lower half.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [X8_W-1:0] x8;
    } trace_t;

    function automatic logic [TRACE_W-1:0] pack_trace(input logic [PC_W-1:0] pc,
                                                      input logic [X8_W-1:0] x8);
        trace_t t;
        t.pc = pc;
        t.x8 = x8;
        return t;
    endfunction

endpackage

// File: rtl/mccoy_trace_fifo.sv
// Synchronous trace FIFO. A push that finds the FIFO full (and not being
// popped in the same cycle) is dropped and flagged on 'drop' for one cycle.
module mccoy_trace_fifo
    import mccoy_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               push,
    input  logic [TRACE_W-1:0] wdata,
    input  logic               pop,
    output logic [TRACE_W-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic               drop
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [TRACE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               push_ok_s, pop_ok_s;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);
    assign rdata = mem_q[rptr_q];
    assign drop  = push & full & ~pop_ok_s;

    // Pointer and occupancy update; a pop frees the slot a full-time push needs.
    always_comb begin
        pop_ok_s  = pop & ~empty;
        push_ok_s = push & (~full | pop_ok_s);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_ok_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer/count registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clr) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mccoy_host.sv
// Host side of the McCoy core: loads a 64x6 program, holds the core in reset
// while loading, then serves instructions by PC and traces {pc, x8} until the
// core halts or the cycle budget runs out.
module mccoy_host
    import mccoy_pkg::*;
#(
    parameter int TRACE_DEPTH = 8,
    parameter int MAX_CYCLES  = 255,
    parameter int HALT_REPEAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               overflow,
    output logic               core_reset,
    output logic [INSTR_W-1:0] core_instr,
    input  logic [PC_W-1:0]    core_pc,
    input  logic [X8_W-1:0]    core_x8,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [TRACE_W-1:0] trace_data
);

    localparam logic [7:0]      MAX_C    = 8'(MAX_CYCLES);
    localparam logic [7:0]      HALT_LIM = 8'(HALT_REPEAT - 1);
    localparam logic [PC_W-1:0] LAST_A   = PC_W'(PROG_DEPTH - 1);

    logic [INSTR_W-1:0] prog_q [PROG_DEPTH];

    state_e          state_q, state_d;
    logic [PC_W-1:0] waddr_q, waddr_d;
    logic            crst_cnt_q, crst_cnt_d;
    logic [7:0]      cyc_q, cyc_d;
    logic [7:0]      halt_q, halt_d;
    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic            prev_vld_q, prev_vld_d;
    logic            load_ready_q, load_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic            overflow_q, overflow_d;
    logic            core_reset_q, core_reset_d;

    logic            prog_we_s;
    logic [PC_W-1:0] prog_wa_s;
    logic            fifo_push_s, fifo_clr_s;
    logic            fifo_full_s, fifo_empty_s, fifo_drop_s;

    assign load_ready  = load_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign core_reset  = core_reset_q;
    assign trace_valid = ~fifo_empty_s;

    mccoy_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (fifo_clr_s),
        .push  (fifo_push_s),
        .wdata (pack_trace(core_pc, core_x8)),
        .pop   (trace_ready),
        .rdata (trace_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .drop  (fifo_drop_s)
    );

    // Instruction fetch is combinational so the core sees prog[pc] in the same cycle.
    always_comb begin
        if (state_q == ST_RUN) begin
            core_instr = prog_q[core_pc];
        end else begin
            core_instr = {INSTR_W{1'b0}};
        end
    end

    // Next-state and next-output logic for load, core-reset and run phases.
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        crst_cnt_d  = crst_cnt_q;
        cyc_d       = cyc_q;
        halt_d      = halt_q;
        prev_pc_d   = prev_pc_q;
        prev_vld_d  = prev_vld_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        prog_we_s   = 1'b0;
        prog_wa_s   = waddr_q;
        fifo_push_s = 1'b0;
        fifo_clr_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    // A load beat wins over start; a single-beat program stays idle.
                    prog_we_s = 1'b1;
                    prog_wa_s = {PC_W{1'b0}};
                    waddr_d   = PC_W'(1);
                    if (load_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (start) begin
                    state_d    = ST_CRST;
                    crst_cnt_d = 1'b0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    prog_we_s = 1'b1;
                    prog_wa_s = waddr_q;
                    waddr_d   = waddr_q + PC_W'(1);
                    if (load_last || (waddr_q == LAST_A)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CRST: begin
                fifo_clr_s = 1'b1;
                cyc_d      = 8'd0;
                halt_d     = 8'd0;
                prev_vld_d = 1'b0;
                done_d     = 1'b0;
                timeout_d  = 1'b0;
                overflow_d = 1'b0;
                if (crst_cnt_q) begin
                    crst_cnt_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    crst_cnt_d = 1'b1;
                    state_d    = ST_CRST;
                end
            end
            ST_RUN: begin
                fifo_push_s = 1'b1;
                cyc_d       = cyc_q + 8'd1;
                if (prev_vld_q && (core_pc == prev_pc_q)) begin
                    halt_d = halt_q + 8'd1;
                end else begin
                    halt_d = 8'd0;
                end
                prev_pc_d  = core_pc;
                prev_vld_d = 1'b1;
                // A drop can only happen while the FIFO is full.
                overflow_d = overflow_q | (fifo_drop_s & fifo_full_s);
                // Budget expiry takes precedence so timeout is reported.
                if (cyc_d == MAX_C) begin
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (halt_d == HALT_LIM) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        load_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        busy_d       = (state_d != ST_IDLE);
        core_reset_d = (state_d != ST_RUN);
    end

    // FSM state, counters and registered outputs; reset forces IDLE with the core held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            waddr_q      <= '0;
            crst_cnt_q   <= 1'b0;
            cyc_q        <= 8'd0;
            halt_q       <= 8'd0;
            prev_pc_q    <= '0;
            prev_vld_q   <= 1'b0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            crst_cnt_q   <= crst_cnt_d;
            cyc_q        <= cyc_d;
            halt_q       <= halt_d;
            prev_pc_q    <= prev_pc_d;
            prev_vld_q   <= prev_vld_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
            core_reset_q <= core_reset_d;
        end
    end

    // Program storage write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (prog_we_s) begin
            prog_q[prog_wa_s] <= load_data;
        end
    end

endmodule

// File: tb/tb_mccoy_host.sv
// Self-checking bench for mccoy_host: random program loads and model-core
// PC sequences checked against a queue-based trace/halt/budget model.
module tb_mccoy_host;
    import mccoy_pkg::*;

    localparam int DEPTH = 8;
    localparam int MAXC  = 20;
    localparam int HREP  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0, load_last = 1'b0, start = 1'b0, trace_ready = 1'b0;
    logic [5:0]  load_data = 6'd0, core_pc = 6'd0, core_x8 = 6'd0;
    logic        load_ready, busy, done, timeout, overflow, core_reset, trace_valid;
    logic [5:0]  core_instr;
    logic [11:0] trace_data;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  m_prog [64];
    logic [11:0] m_q [$];
    logic        m_ovf;
    int          pc_seq [$];
    logic [5:0]  ld_vals [$];

    always #5 clk = ~clk;

    mccoy_host #(.TRACE_DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_REPEAT(HREP)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
        .start(start), .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
        .core_reset(core_reset), .core_instr(core_instr), .core_pc(core_pc), .core_x8(core_x8),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got %0b exp 1", load_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b exp 0", overflow); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL rst_core_reset got %0b exp 1", core_reset); end
        checks++; if (core_instr !== 6'd0) begin errors++; $display("FAIL rst_core_instr got %0h exp 0", core_instr); end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL rst_trace_valid got %0b exp 0", trace_valid); end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // Drive ld_vals as beats from IDLE; start is held high on the first three beats.
    task automatic load_beats(input int n, input bit use_last, input bit with_start);
        bit   last_i;
        logic exp_busy;
        for (int i = 0; i < n; i++) begin
            last_i     = use_last && (i == n - 1);
            load_valid = 1'b1;
            load_data  = ld_vals[i];
            load_last  = last_i;
            start      = with_start && (i < 3);
            checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_pre beat %0d got %0b exp 1", i, load_ready); end
            tick();
            m_prog[i % 64] = ld_vals[i];
            exp_busy = !(last_i || (i == 63));
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL load_busy beat %0d got %0b exp %0b", i, busy, exp_busy); end
            checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_post beat %0d got %0b exp 1", i, load_ready); end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        start      = 1'b0;
    endtask

    task automatic test_load64();
        ld_vals.delete();
        for (int i = 0; i < 64; i++) ld_vals.push_back(6'($urandom_range(0, 63)));
        load_beats(64, 1'b0, 1'b0);
        checks++; if (dut.waddr_q !== 6'd0) begin errors++; $display("FAIL load64_waddr got %0d exp 0", dut.waddr_q); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load64_idle got %0b exp 0", busy); end
    endtask

    task automatic test_load4();
        ld_vals.delete();
        ld_vals.push_back(6'h01);
        ld_vals.push_back(6'h0A);
        ld_vals.push_back(6'h13);
        ld_vals.push_back(6'h3F);
        load_beats(4, 1'b1, 1'b1);
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load4_idle got %0b exp 0", busy); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load4_ready got %0b exp 1", load_ready); end
    endtask

    // Accept start, then walk through the two core-reset cycles into RUN.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %0b exp 1", busy); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL crst1 got %0b exp 1", core_reset); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL start_done_clr got %0b exp 0", done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL start_timeout_clr got %0b exp 0", timeout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL start_overflow_clr got %0b exp 0", overflow); end
        tick();
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL crst2 got %0b exp 1", core_reset); end
        tick();
        checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL run_core_reset got %0b exp 0", core_reset); end
    endtask

    // Play pc_seq as the core; the model decides when the run must end.
    task automatic run_seq(input bit rand_ready);
        int         run_len;
        int         prev;
        bit         ended;
        bit         exp_to;
        bit         full;
        bit         pop_ok;
        logic [5:0] pcv;
        logic [5:0] x8;
        run_len = 0;
        prev    = -1;
        ended   = 1'b0;
        exp_to  = 1'b0;
        for (int k = 0; k < pc_seq.size() && !ended; k++) begin
            pcv         = 6'(pc_seq[k]);
            x8          = 6'($urandom_range(0, 63));
            core_pc     = pcv;
            core_x8     = x8;
            trace_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            checks++; if (core_instr !== m_prog[pcv]) begin errors++; $display("FAIL fetch pc %0d got %0h exp %0h", pcv, core_instr, m_prog[pcv]); end
            checks++; if (trace_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL run_trace_valid cyc %0d got %0b exp %0b", k, trace_valid, m_q.size() > 0); end
            full   = (m_q.size() == DEPTH);
            pop_ok = trace_ready && (m_q.size() > 0);
            if (pop_ok) begin
                checks++; if (trace_data !== m_q[0]) begin errors++; $display("FAIL run_pop_data got %0h exp %0h", trace_data, m_q[0]); end
                void'(m_q.pop_front());
            end
            if (!full || pop_ok) m_q.push_back({pcv, x8});
            else m_ovf = 1'b1;
            run_len = (int'(pcv) == prev) ? run_len + 1 : 1;
            prev    = int'(pcv);
            if (k + 1 == MAXC) begin
                ended  = 1'b1;
                exp_to = 1'b1;
            end else if (run_len >= HREP) begin
                ended = 1'b1;
            end
            tick();
        end
        trace_ready = 1'b0;
        if (!ended) begin
            checks++; errors++;
            $display("FAIL run_seq_budget got no end after %0d cycles exp an end", pc_seq.size());
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL end_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_done got %0b exp 1", done); end
        checks++; if (timeout !== exp_to) begin errors++; $display("FAIL end_timeout got %0b exp %0b", timeout, exp_to); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL end_overflow got %0b exp %0b", overflow, m_ovf); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL end_core_reset got %0b exp 1", core_reset); end
        checks++; if (core_instr !== 6'd0) begin errors++; $display("FAIL end_core_instr got %0h exp 0", core_instr); end
    endtask

    // Read the FIFO out after the run and compare with the model queue.
    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (m_q.size() == 0) break;
            checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL drain_valid idx %0d got %0b exp 1", i, trace_valid); end
            checks++; if (trace_data !== m_q[0]) begin errors++; $display("FAIL drain_data idx %0d got %0h exp %0h", i, trace_data, m_q[0]); end
            trace_ready = 1'b1;
            tick();
            trace_ready = 1'b0;
            void'(m_q.pop_front());
        end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", trace_valid); end
    endtask

    task automatic test_fetch();
        pc_seq = '{0, 1, 2, 3, 3};
        do_start();
        run_seq(1'b0);
        drain();
    endtask

    task automatic test_halt();
        pc_seq = '{0, 1, 5, 5, 6, 7};
        do_start();
        run_seq(1'b0);
        drain();
    endtask

    task automatic test_timeout();
        pc_seq.delete();
        for (int i = 0; i < MAXC + 5; i++) pc_seq.push_back(i % 64);
        do_start();
        run_seq(1'b0);
        drain();
    endtask

    task automatic test_both_end();
        pc_seq.delete();
        for (int i = 0; i < MAXC - 1; i++) pc_seq.push_back((i * 3 + 7) % 64);
        pc_seq.push_back((MAXC - 2) * 3 % 64 + 7 >= 64 ? ((MAXC - 2) * 3 + 7) % 64 : (MAXC - 2) * 3 + 7);
        pc_seq.push_back(0);
        do_start();
        run_seq(1'b0);
        drain();
    endtask

    task automatic build_random_seq();
        int len;
        int p;
        int last;
        pc_seq.delete();
        len  = $urandom_range(4, 15);
        last = -1;
        for (int i = 0; i < len; i++) begin
            p = $urandom_range(0, 63);
            if (p == last) p = (p + 1) % 64;
            pc_seq.push_back(p);
            last = p;
        end
        pc_seq.push_back(last);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++) begin
            build_random_seq();
            do_start();
            run_seq(1'b1);
            drain();
        end
    endtask

    task automatic test_reset_midrun();
        do_start();
        core_pc = 6'd0;
        tick();
        core_pc = 6'd1;
        tick();
        core_pc = 6'd2;
        #1;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %0b exp 0", busy); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL mid_rst_core_reset got %0b exp 1", core_reset); end
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_trace_valid got %0b exp 0", trace_valid); end
        checks++; if (core_instr !== 6'd0) begin errors++; $display("FAIL mid_rst_core_instr got %0h exp 0", core_instr); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_load_ready got %0b exp 1", load_ready); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        m_q.delete();
        build_random_seq();
        do_start();
        run_seq(1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_load64();
        test_load4();
        test_fetch();
        test_halt();
        test_timeout();
        test_both_end();
        test_random_runs();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mccoy_host.md
# mccoy_host

Host-side companion to the McCoy core and the other end of its 6-bit instruction/PC interface. It stores a program of up to 64 six-bit instructions loaded over a valid/ready port, holds the core in reset during load, and releases it to run. While running it returns `prog[pc]` for each PC the core presents and captures a `{pc, x8}` trace into a small FIFO. It ends the run when the core halts (PC stuck) or a cycle budget expires.

## Interface
- `TRACE_DEPTH`, 8: trace FIFO entries; must be a power of two.
- `MAX_CYCLES`, 255: RUN-cycle budget before a forced stop; 8-bit counter.
- `HALT_REPEAT`, 2: number of consecutive RUN cycles with an unchanged PC that counts as a halt.
- `clk` in 1: the single clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `load_valid` in 1, `load_ready` out 1, `load_data` in 6, `load_last` in 1: program load beats.
- `start` in 1: level-sampled run request.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: sticky; set when a run ends, cleared by an accepted `start`.
- `timeout` out 1: sticky; set when a run ends by the cycle budget, cleared by an accepted `start`.
- `overflow` out 1: sticky; set when a trace push is dropped, cleared by an accepted `start`.
- `core_reset` out 1: active-high reset driven to the core.
- `core_instr` out 6: instruction to the core.
- `core_pc` in 6: PC from the core.
- `core_x8` in 6: x8 value from the core.
- `trace_valid` out 1, `trace_ready` in 1, `trace_data` out 12: trace FIFO read port; `trace_data` = {pc[11:6], x8[5:0]}.

## Operation
- FSM states: IDLE, LOAD, CRST, RUN.
- IDLE:
  - `load_ready`=1.
  - An accepted beat writes `prog[0]`, sets `waddr`=1 and moves to LOAD. If that beat has `load_last`=1, the FSM stays in IDLE instead.
  - Otherwise `start`=1 moves to CRST.
  - A load beat has priority over `start` in the same cycle.
- LOAD:
  - `load_ready`=1; each accepted beat writes `prog[waddr]` and increments `waddr`.
  - The FSM returns to IDLE on a beat with `load_last`=1, or on the beat written to address 63.
  - `start` is ignored.
- CRST:
  - Lasts 2 cycles with `core_reset`=1.
  - Clears the cycle counter, the halt counter, the FIFO and all sticky flags, then moves to RUN.
- RUN:
  - `core_reset`=0.
  - `core_instr`=`prog[core_pc]`, combinational.
  - Every cycle pushes {`core_pc`, `core_x8`} into the FIFO and increments the cycle counter.
  - If `core_pc` equals the previous RUN cycle's PC, the halt counter increments; otherwise it clears.
  - Halt counter reaching HALT_REPEAT−1 sets `done` and returns to IDLE.
  - Cycle counter reaching MAX_CYCLES sets `done` and `timeout` and returns to IDLE.
  - If both end conditions hit in the same cycle, `timeout` is set.
- Outside RUN: `core_reset`=1 and `core_instr`=0.
- Trace FIFO:
  - A push while full is dropped and sets `overflow`; existing contents are kept.
  - A simultaneous push and pop while full is accepted.
  - Pops are allowed in any state; the FIFO is read out after the run.
- `prog` is not reset. Only loaded addresses are defined, and loading does not clear the rest of the array.

## Timing
- Reset values:
  - FSM=IDLE.
  - `load_ready`=1, `busy`=0, `done`=0, `timeout`=0, `overflow`=0.
  - `core_reset`=1, `core_instr`=0, `trace_valid`=0.
  - `waddr`, all counters and FIFO pointers = 0.
- `start` accepted at edge N: CRST at N+1 and N+2, RUN from N+3. The first trace entry is captured at edge N+3 with the core's post-reset PC (0).
- `core_instr` has zero latency from `core_pc`, so the core sees the matching instruction in the same cycle.
- `trace_valid` rises the cycle after the first push.
- A write to `prog` becomes visible on the next cycle.
- `reset` asserted mid-run:
  - The FSM returns to IDLE immediately and `core_reset`=1 asynchronously.
  - The FIFO is emptied.
  - `prog` contents are retained.

## Structure
- Shared package `mccoy_pkg` holds:
  - `INSTR_W`=6 and `PC_W`=6.
  - The FSM state enum.
  - The trace word layout.
- One sub-module, `mccoy_trace_fifo`: a synchronous FIFO of width 12 and depth TRACE_DEPTH, with full/empty outputs and a drop-on-full output that is registered into `overflow`.
- The program array is inferred 64×6 storage with one write port and one combinational read port.

## Test plan
- Load 4 beats [0x01, 0x0A, 0x13, 0x3F] with `load_last` on the 4th -> `prog[0..3]` match; FSM back in IDLE; `load_ready` stays 1.
- Load 64 beats with no `load_last` -> return to IDLE after address 63; `waddr` wraps to 0.
- `start` at edge N -> `core_reset`=1 at N+1 and N+2, 0 at N+3; a model core presenting pc=2 receives `core_instr`=`prog[2]` in the same cycle.
- Model core holds pc=5 for 2 cycles -> `done`=1, `timeout`=0; the trace ends with two entries {5, x8}.
- Model core increments PC forever with MAX_CYCLES=20 -> `done`=1 and `timeout`=1 after 20 RUN cycles; `overflow`=1 because the 8-deep FIFO was never popped; the first 8 entries are retained.
- `reset` pulsed low in the 3rd RUN cycle -> IDLE, `core_reset`=1 and `trace_valid`=0 immediately; a following `start` runs the retained program with no reload.
